// File: rtl/mips32_mem_arbiter_pkg.sv
// Shared types and constants for the mips32 unified-memory arbiter.
package mips32_mem_pkg;

    localparam int AW_DEFAULT = 10;

    // Arbiter ownership phases: core traffic, drain into a loader session,
    // loader-owned session, and drain back out to core traffic.
    typedef enum logic [1:0] {
        RUN       = 2'd0,
        DRAIN_IN  = 2'd1,
        LOCK      = 2'd2,
        DRAIN_OUT = 2'd3
    } arb_state_t;

    // Which requester the read data returning next cycle belongs to.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_LD   = 2'd1,
        OWN_D    = 2'd2,
        OWN_F    = 2'd3
    } owner_t;

endpackage

// File: rtl/mips32_mem_arbiter_if.sv
// Request/grant/response bundle between the three requesters, the arbiter
// and the single-port memory. The arbiter uses the slave modport; whatever
// drives requests and models the memory uses the master modport.
interface mips32_mem_arbiter_if #(
    parameter int AW = 10
);
    // loader / debug port
    logic          ld_lock;
    logic          ld_req;
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_wdata;
    logic          ld_gnt;
    logic          ld_rvalid;
    logic          ld_owned;
    // MEM-stage data port
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    // IF-stage fetch port
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_gnt;
    logic          f_rvalid;
    // shared response and pipeline freeze
    logic [31:0]   rdata;
    logic          core_hold;
    // memory side
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport slave (
        input  ld_lock, ld_req, ld_we, ld_addr, ld_wdata,
        output ld_gnt, ld_rvalid, ld_owned,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid,
        input  f_req, f_addr,
        output f_gnt, f_rvalid,
        output rdata, core_hold,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output ld_lock, ld_req, ld_we, ld_addr, ld_wdata,
        input  ld_gnt, ld_rvalid, ld_owned,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid,
        output f_req, f_addr,
        input  f_gnt, f_rvalid,
        input  rdata, core_hold,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mips32_mem_arbiter_starve_ctr.sv
// Saturating starvation counter: counts up on inc until LIMIT, clears on clr,
// holds otherwise (so the caller freezes it simply by asserting neither).
module mips32_starve_ctr #(
    parameter int LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] cnt,
    output logic       sat
);

    localparam logic [3:0] LIMIT_V = 4'(LIMIT);

    logic [3:0] cnt_reg;

    // count / clear / hold, saturating at LIMIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (inc && (cnt_reg != LIMIT_V)) begin
            cnt_reg <= cnt_reg + 4'd1;
        end
    end

    assign cnt = cnt_reg;
    assign sat = (cnt_reg == LIMIT_V);

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Single-port memory arbiter for the mips32 core: loader/debug, MEM-stage
// data and IF-stage fetch share one 32-bit memory with 1-cycle read latency.
// Optional build macro: MEM_ARB_PERF_EN adds stall/lock performance counters.
module mips32_mem_arbiter
    import mips32_mem_pkg::*;
#(
    parameter int AW           = AW_DEFAULT,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   clk1,
    input  logic                   rst,
    mips32_mem_arbiter_if.slave    bus
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]            perf_d_stall,
    output logic [31:0]            perf_f_stall,
    output logic [31:0]            perf_lock_cycles
`endif
);

    arb_state_t    state_reg, state_next;
    owner_t        rsp_owner_reg, rsp_owner_next;

    logic          ld_gnt, d_gnt, f_gnt;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;

    logic          starve_inc, starve_clr, starve_sat;
    logic [3:0]    starve_cnt;

    // fetch starvation tracking; only RUN moves the counter, other states freeze it
    assign starve_inc = (state_reg == RUN) && bus.f_req && !f_gnt;
    assign starve_clr = (state_reg == RUN) && (f_gnt || !bus.f_req);

    mips32_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_f_starve (
        .clk (clk1),
        .rst (rst),
        .inc (starve_inc),
        .clr (starve_clr),
        .cnt (starve_cnt),
        .sat (starve_sat)
    );

    // state and read-response owner registers
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_reg     <= RUN;
            rsp_owner_reg <= OWN_NONE;
        end else begin
            state_reg     <= state_next;
            rsp_owner_reg <= rsp_owner_next;
        end
    end

    // next state, grant selection and memory strobe mux
    always_comb begin
        state_next     = state_reg;
        rsp_owner_next = OWN_NONE;
        ld_gnt         = 1'b0;
        d_gnt          = 1'b0;
        f_gnt          = 1'b0;
        mem_en         = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;

        case (state_reg)
            RUN: begin
                // a lock request wins the cycle outright: no core grant, the
                // core keeps its request up and is served after the session
                if (bus.ld_lock) begin
                    state_next = DRAIN_IN;
                end else if (bus.f_req && (starve_sat || !bus.d_req)) begin
                    f_gnt = 1'b1;
                end else if (bus.d_req) begin
                    d_gnt = 1'b1;
                end
            end
            DRAIN_IN: begin
                if (rsp_owner_reg == OWN_NONE) begin
                    state_next = LOCK;
                end
            end
            LOCK: begin
                ld_gnt = bus.ld_req;
                if (!bus.ld_lock) begin
                    state_next = DRAIN_OUT;
                end
            end
            DRAIN_OUT: begin
                if (rsp_owner_reg != OWN_LD) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase

        // grants are combinational, so mask them while reset is held to keep
        // every output quiet for the whole reset pulse
        if (rst) begin
            ld_gnt = 1'b0;
            d_gnt  = 1'b0;
            f_gnt  = 1'b0;
        end

        if (ld_gnt) begin
            mem_en    = 1'b1;
            mem_we    = bus.ld_we;
            mem_addr  = bus.ld_addr;
            mem_wdata = bus.ld_wdata;
            if (!bus.ld_we) rsp_owner_next = OWN_LD;
        end else if (d_gnt) begin
            mem_en    = 1'b1;
            mem_we    = bus.d_we;
            mem_addr  = bus.d_addr;
            mem_wdata = bus.d_wdata;
            if (!bus.d_we) rsp_owner_next = OWN_D;
        end else if (f_gnt) begin
            mem_en         = 1'b1;
            mem_addr       = bus.f_addr;
            rsp_owner_next = OWN_F;
        end
    end

    assign bus.ld_gnt    = ld_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.f_gnt     = f_gnt;
    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;

    assign bus.ld_owned  = (state_reg == LOCK);
    assign bus.core_hold = (state_reg == DRAIN_IN) || (state_reg == LOCK);

    // the registered owner steers the shared read data to exactly one port
    assign bus.ld_rvalid = (rsp_owner_reg == OWN_LD);
    assign bus.d_rvalid  = (rsp_owner_reg == OWN_D);
    assign bus.f_rvalid  = (rsp_owner_reg == OWN_F);
    assign bus.rdata     = (rsp_owner_reg != OWN_NONE) ? bus.mem_rdata : 32'd0;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_d_stall_reg, perf_f_stall_reg, perf_lock_cycles_reg;

    // free-running, wrapping performance counters
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            perf_d_stall_reg     <= '0;
            perf_f_stall_reg     <= '0;
            perf_lock_cycles_reg <= '0;
        end else begin
            if (bus.d_req && !d_gnt)  perf_d_stall_reg     <= perf_d_stall_reg + 32'd1;
            if (bus.f_req && !f_gnt)  perf_f_stall_reg     <= perf_f_stall_reg + 32'd1;
            if (state_reg == LOCK)    perf_lock_cycles_reg <= perf_lock_cycles_reg + 32'd1;
        end
    end

    assign perf_d_stall     = perf_d_stall_reg;
    assign perf_f_stall     = perf_f_stall_reg;
    assign perf_lock_cycles = perf_lock_cycles_reg;
`endif

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Directed bench for mips32_mem_arbiter. Inputs change on the falling edge,
// outputs are sampled 1 ns later, well away from the rising (active) edge.
module tb_mips32_mem_arbiter;

    localparam int AW = 10;

    logic clk1 = 1'b0;
    logic rst  = 1'b1;
    always #5 clk1 = ~clk1;

    mips32_mem_arbiter_if #(.AW(AW)) bus();

`ifdef MEM_ARB_PERF_EN
    logic [31:0] pd, pf, pl;
`endif

    mips32_mem_arbiter #(.AW(AW), .STARVE_LIMIT(4)) dut (
        .clk1 (clk1),
        .rst  (rst),
        .bus  (bus)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_d_stall     (pd),
        .perf_f_stall     (pf),
        .perf_lock_cycles (pl)
`endif
    );

    // behavioural single-port memory with registered read
    logic [31:0] mem [0:(1<<AW)-1];
    always @(posedge clk1) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= mem[bus.mem_addr];
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic rst2 = 1'b1;
    logic [31:0] pd2, pf2, pl2;
    mips32_mem_arbiter_if #(.AW(AW)) bus2();
    assign bus2.mem_rdata = 32'd0;
    mips32_mem_arbiter #(.AW(AW), .STARVE_LIMIT(15)) dut2 (
        .clk1 (clk1),
        .rst  (rst2),
        .bus  (bus2),
        .perf_d_stall     (pd2),
        .perf_f_stall     (pf2),
        .perf_lock_cycles (pl2)
    );
`endif

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    // loader image: fixed words at 0, 35, 36; filler elsewhere; word 37 -> addr 40
    function automatic logic [31:0] prog_word(input int i);
        case (i)
            0:       return 32'h28020000;
            35:      return 32'h3800ffe3;
            36:      return 32'h0ce77800;
            37:      return 32'hcafe0040;
            default: return 32'h10000000 + 32'(i * 4);
        endcase
    endfunction

    initial begin
        int rb_addr [3];
        logic [31:0] rb_exp [3];
        rb_addr = '{35, 0, 36};
        rb_exp  = '{32'h3800ffe3, 32'h28020000, 32'h0ce77800};

        bus.ld_lock = 0; bus.ld_req = 0; bus.ld_we = 0; bus.ld_addr = '0; bus.ld_wdata = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.f_req = 0; bus.f_addr = '0;
`ifdef MEM_ARB_PERF_EN
        bus2.ld_lock = 0; bus2.ld_req = 0; bus2.ld_we = 0; bus2.ld_addr = '0; bus2.ld_wdata = '0;
        bus2.d_req = 0; bus2.d_we = 0; bus2.d_addr = '0; bus2.d_wdata = '0;
        bus2.f_req = 0; bus2.f_addr = '0;
`endif

        // --- reset state, even with a request present
        repeat (2) @(negedge clk1);
        bus.d_req = 1; #1;
        check("rst_d_gnt", bus.d_gnt, 0);
        check("rst_mem_en", bus.mem_en, 0);
        check("rst_core_hold", bus.core_hold, 0);
        check("rst_ld_owned", bus.ld_owned, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_rvalids", {bus.ld_rvalid, bus.d_rvalid, bus.f_rvalid}, 0);
        bus.d_req = 0;

        // --- loader request without ownership is ignored
        @(negedge clk1); rst = 0; bus.ld_req = 1; #1;
        check("noown_ld_gnt", bus.ld_gnt, 0);
        bus.ld_req = 0;

        // --- lock session: owned two cycles after lock, fetch held off
        @(negedge clk1); bus.ld_lock = 1; bus.f_req = 1; #1;
        check("lock0_f_gnt", bus.f_gnt, 0);
        check("lock0_owned", bus.ld_owned, 0);
        @(negedge clk1); #1;
        check("drain_in_hold", bus.core_hold, 1);
        check("drain_in_owned", bus.ld_owned, 0);
        @(negedge clk1); #1;
        check("lock_owned", bus.ld_owned, 1);
        check("lock_f_gnt", bus.f_gnt, 0);
        bus.f_req = 0;

        for (int i = 0; i < 38; i++) begin
            @(negedge clk1);
            bus.ld_req = 1; bus.ld_we = 1;
            bus.ld_addr = (i == 37) ? AW'(40) : AW'(i);
            bus.ld_wdata = prog_word(i); #1;
            check($sformatf("ld_wr%0d_gnt", i), bus.ld_gnt, 1);
            check($sformatf("ld_wr%0d_hold", i), bus.core_hold, 1);
        end

        for (int k = 0; k < 3; k++) begin
            @(negedge clk1);
            bus.ld_req = 1; bus.ld_we = 0; bus.ld_addr = AW'(rb_addr[k]); bus.d_req = 1; #1;
            check("ld_rd_gnt", bus.ld_gnt, 1);
            check("lock_d_gnt", bus.d_gnt, 0);
            @(negedge clk1); bus.ld_req = 0; bus.d_req = 0; #1;
            check("ld_rvalid", bus.ld_rvalid, 1);
            check($sformatf("ld_rdata%0d", rb_addr[k]), bus.rdata, rb_exp[k]);
            check("ld_rd_d_rvalid", bus.d_rvalid, 0);
        end

        // --- unlock: LOCK -> DRAIN_OUT -> RUN
        @(negedge clk1); bus.ld_lock = 0; #1;
        check("unlock_owned_still", bus.ld_owned, 1);
        @(negedge clk1); bus.d_req = 1; #1;
        check("drain_out_owned", bus.ld_owned, 0);
        check("drain_out_hold", bus.core_hold, 0);
        check("drain_out_d_gnt", bus.d_gnt, 0);
        @(negedge clk1); #1;
        check("run_d_gnt", bus.d_gnt, 1);
        @(negedge clk1); bus.d_req = 0;

        // --- starvation: both held, pattern d d d d f
        for (int k = 0; k < 10; k++) begin
            @(negedge clk1);
            bus.d_req = 1; bus.f_req = 1; bus.d_addr = AW'(0); bus.f_addr = AW'(1); #1;
            check($sformatf("starve%0d_d_gnt", k), bus.d_gnt, (k % 5 != 4) ? 1 : 0);
            check($sformatf("starve%0d_f_gnt", k), bus.f_gnt, (k % 5 == 4) ? 1 : 0);
        end

        // --- back-to-back reads from different owners route correctly
        @(negedge clk1); bus.d_req = 0; bus.f_req = 1; bus.f_addr = AW'(7); #1;
        check("b2b_f_gnt", bus.f_gnt, 1);
        @(negedge clk1); bus.f_req = 0; bus.d_req = 1; bus.d_addr = AW'(40); #1;
        check("b2b_d_gnt", bus.d_gnt, 1);
        check("b2b_f_rvalid", bus.f_rvalid, 1);
        check("b2b_d_rvalid_early", bus.d_rvalid, 0);
        check("b2b_f_rdata", bus.rdata, 32'h1000001c);
        @(negedge clk1); bus.d_req = 0; #1;
        check("b2b_d_rvalid", bus.d_rvalid, 1);
        check("b2b_f_rvalid_late", bus.f_rvalid, 0);
        check("b2b_d_rdata", bus.rdata, 32'hcafe0040);

        // --- data write then read back; writes return no rvalid
        @(negedge clk1); bus.d_req = 1; bus.d_we = 1; bus.d_addr = AW'(50); bus.d_wdata = 32'h12345678; #1;
        check("dwr_gnt", bus.d_gnt, 1);
        check("dwr_mem_we", bus.mem_we, 1);
        @(negedge clk1); bus.d_we = 0; #1;
        check("dwr_no_rvalid", bus.d_rvalid, 0);
        check("drd_gnt", bus.d_gnt, 1);
        @(negedge clk1); bus.d_req = 0; #1;
        check("drd_rvalid", bus.d_rvalid, 1);
        check("drd_rdata", bus.rdata, 32'h12345678);

        // --- lock right after a granted fetch read
        @(negedge clk1); bus.f_req = 1; bus.f_addr = AW'(7); #1;
        check("lf_f_gnt", bus.f_gnt, 1);
        @(negedge clk1); bus.ld_lock = 1; #1;
        check("lf_f_gnt_blocked", bus.f_gnt, 0);
        check("lf_f_rvalid", bus.f_rvalid, 1);
        check("lf_f_rdata", bus.rdata, 32'h1000001c);
        check("lf_hold_run", bus.core_hold, 0);
        @(negedge clk1); bus.d_req = 1; #1;
        check("lf_drain_hold", bus.core_hold, 1);
        check("lf_drain_owned", bus.ld_owned, 0);
        check("lf_drain_gnts", {bus.d_gnt, bus.f_gnt, bus.f_rvalid}, 0);
        @(negedge clk1); #1;
        check("lf_owned", bus.ld_owned, 1);
        check("lf_lock_gnts", {bus.d_gnt, bus.f_gnt}, 0);

        // --- reset mid-LOCK returns to RUN
        @(negedge clk1); rst = 1; #1;
        check("rstlock_hold", bus.core_hold, 0);
        check("rstlock_owned", bus.ld_owned, 0);
        check("rstlock_mem_en", bus.mem_en, 0);
        @(negedge clk1); rst = 0; bus.ld_lock = 0; bus.f_req = 0; bus.d_req = 0; #1;
        check("rstlock_hold_after", bus.core_hold, 0);

        // --- reset between a read grant and its response
        @(negedge clk1); bus.d_req = 1; bus.d_addr = AW'(40); #1;
        check("rstrd_gnt", bus.d_gnt, 1);
        #2 rst = 1;
        @(posedge clk1); #1;
        check("rstrd_rvalid", bus.d_rvalid, 0);
        check("rstrd_rdata", bus.rdata, 0);
        check("rstrd_outs", {bus.d_gnt, bus.f_gnt, bus.ld_gnt, bus.mem_en, bus.mem_we, bus.core_hold, bus.ld_owned}, 0);
        @(negedge clk1); bus.d_req = 0; rst = 0; #1;
        check("rstrd_rvalid_after", bus.d_rvalid, 0);
        @(negedge clk1); bus.d_req = 1; #1;
        check("post_rst_d_gnt", bus.d_gnt, 1);
        @(negedge clk1); bus.d_req = 0; #1;
        check("post_rst_rdata", bus.rdata, 32'hcafe0040);

`ifdef MEM_ARB_PERF_EN
        // --- perf counters: 10 cycles of fetch starved by data, limit 15
        @(negedge clk1); rst2 = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk1); bus2.d_req = 1; bus2.f_req = 1; #1;
            check("perf_f_denied", bus2.f_gnt, 0);
        end
        @(negedge clk1); bus2.d_req = 0; bus2.f_req = 0; #1;
        check("perf_f_stall", pf2, 32'd10);
        check("perf_d_stall", pd2, 32'd0);
        check("perf_lock_cycles", pl2, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
